// File: rtl/alu_pkg.sv
// alu_pkg: instruction codes, sequencer states and flag layout shared with the ALU decoder ROM
package alu_pkg;
  localparam logic [3:0] I_NOP = 4'h0;
  localparam logic [3:0] I_RS1 = 4'h1;
  localparam logic [3:0] I_RS2 = 4'h2;
  localparam logic [3:0] I_RS3 = 4'h3;
  localparam logic [3:0] I_EXE = 4'h4;
  localparam logic [3:0] I_WS1 = 4'h8;
  localparam logic [3:0] I_WS2 = 4'h9;
  localparam logic [3:0] I_RST = 4'hF;
  typedef enum logic [3:0] {IDLE, CLR, LDA, LDB, LDOP, EXE, TURN_W, RDR, RDF, RESP} state_t;
  typedef struct packed {
    logic z;
    logic c;
    logic o;
    logic n;
  } flags_t;
endpackage

// File: rtl/alu_sequencer_if.sv
// alu_sequencer_if: request/response handshake between the control FSM and the sequencer
interface alu_sequencer_if
  import alu_pkg::*;
#(parameter int W = 4);
  logic req_valid;
  logic req_ready;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic [W-1:0] req_op;
  logic [1:0] req_sel;
  logic req_clr;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_res;
  flags_t rsp_flags;
  modport master(output req_valid, req_a, req_b, req_op, req_sel, req_clr, rsp_ready,
                 input req_ready, rsp_valid, rsp_res, rsp_flags);
  modport slave(input req_valid, req_a, req_b, req_op, req_sel, req_clr, rsp_ready,
                output req_ready, rsp_valid, rsp_res, rsp_flags);
endinterface

// File: rtl/bus_tristate.sv
// bus_tristate: output-enable driver for a shared inout bus, with read-back of the bus value
module bus_tristate #(parameter int W = 4) (
  input  logic         oe,
  input  logic [W-1:0] d,
  inout  wire  [W-1:0] bus,
  output logic [W-1:0] q
);
  assign bus = oe ? d : {W{1'bz}};
  assign q = bus;
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: issues load/execute/read microcode to the ALU unit for one handshaked request
module alu_sequencer
  import alu_pkg::*;
#(parameter int W = 4, parameter int TURN = 1) (
  input  logic              clk,
  input  logic              grst,
  alu_sequencer_if.slave    ctl,
  output logic [3:0]        instr,
  inout  wire  [W-1:0]      bus
);
  state_t state, nxt;
  logic [W-1:0] b, op, dout, nd, bus_q;
  logic [1:0] sel, cnt;
  logic [3:0] ni;
  logic oe, rdy, ld;
  assign ctl.req_ready = rdy;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:   if (ctl.req_valid && rdy) nxt = ctl.req_clr ? CLR : LDA;
      CLR:    nxt = IDLE;
      LDA:    nxt = LDB;
      LDB:    nxt = LDOP;
      LDOP:   nxt = EXE;
      EXE:    nxt = (TURN == 0) ? RDR : TURN_W;
      TURN_W: if (cnt == 2'd0) nxt = RDR;
      RDR:    nxt = RDF;
      RDF:    nxt = RESP;
      RESP:   if (ctl.rsp_ready) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // instr, bus data and enable are registered from the next state so they align with it glitch-free
  always_comb begin
    ni = (nxt == CLR)  ? I_RST :
         (nxt == LDA)  ? I_RS1 :
         (nxt == LDB)  ? I_RS2 :
         (nxt == LDOP) ? I_RS3 :
         (nxt == EXE)  ? I_EXE + {2'b00, sel} :
         (nxt == RDR)  ? I_WS1 :
         (nxt == RDF)  ? I_WS2 : I_NOP;
    ld = (nxt == LDA) || (nxt == LDB) || (nxt == LDOP);
    nd = (nxt == LDA) ? ctl.req_a : (nxt == LDB) ? b : op;
  end
  always_ff @(posedge clk or negedge grst)
    if (!grst) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge grst)
    if (!grst) begin
      instr <= I_NOP;
      oe <= 1'b0;
      dout <= '0;
      rdy <= 1'b0;
      cnt <= 2'd0;
      b <= '0;
      op <= '0;
      sel <= 2'd0;
      ctl.rsp_valid <= 1'b0;
      ctl.rsp_res <= '0;
      ctl.rsp_flags <= '0;
    end else begin
      instr <= ni;
      oe <= ld;
      dout <= ld ? nd : '0;
      rdy <= (nxt == IDLE);
      ctl.rsp_valid <= (nxt == RESP);
      if (state == IDLE && ctl.req_valid && rdy) begin
        b <= ctl.req_b;
        op <= ctl.req_op;
        sel <= ctl.req_sel;
      end
      if (state == EXE) cnt <= 2'(TURN - 1);
      else if (state == TURN_W && cnt != 2'd0) cnt <= cnt - 2'd1;
      if (state == RDR) ctl.rsp_res <= bus_q;
      if (state == RDF) ctl.rsp_flags <= bus_q[3:0];
    end
  bus_tristate #(.W(W)) u_drv (.oe(oe), .d(dout), .bus(bus), .q(bus_q));
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors against TURN=1, plus TURN=0 and TURN=3 latency/trace builds
module tb_alu_sequencer;
  import alu_pkg::*;
  logic clk = 1'b0;
  logic grst = 1'b0;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_bad = 0;
  int overlap = 0;
  logic prev_oe = 1'b0;
  logic prev_stub = 1'b0;
  logic [3:0] res_v = 4'h0;
  logic [3:0] flg_v = 4'h0;
  logic [3:0] instr;
  logic stub_en;
  wire [3:0] bus;
  alu_sequencer_if #(.W(4)) sq();
  assign stub_en = (instr == I_WS1) || (instr == I_WS2);
  assign bus = (instr == I_WS1) ? res_v : (instr == I_WS2) ? flg_v : 4'bz;
  alu_sequencer #(.W(4), .TURN(1)) dut (.clk(clk), .grst(grst), .ctl(sq.slave), .instr(instr), .bus(bus));

  always @(negedge clk) begin
    if ((dut.oe && (stub_en || prev_stub)) || (prev_oe && stub_en)) overlap++;
    prev_oe = dut.oe;
    prev_stub = stub_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                       input logic [1:0] sel, input logic clr);
    for (int w = 0; w < 20 && !sq.req_ready; w++) step;
    chk("issue_ready", 32'(sq.req_ready), 1);
    sq.req_a = a;
    sq.req_b = b;
    sq.req_op = op;
    sq.req_sel = sel;
    sq.req_clr = clr;
    sq.req_valid = 1'b1;
    step;
    sq.req_valid = 1'b0;
    sq.req_clr = 1'b0;
    sq.req_a = 4'hF;
    sq.req_b = 4'hF;
    sq.req_op = 4'hF;
  endtask

  for (genvar g = 0; g < 2; g++) begin : ext
    localparam int T = (g == 0) ? 0 : 3;
    logic xrst = 1'b0;
    logic fin = 1'b0;
    logic [3:0] xi;
    wire [3:0] xb;
    alu_sequencer_if #(.W(4)) xs();
    assign xb = (xi == I_WS1) ? 4'h6 : (xi == I_WS2) ? 4'h9 : 4'bz;
    alu_sequencer #(.W(4), .TURN(T)) u (.clk(clk), .grst(xrst), .ctl(xs.slave), .instr(xi), .bus(xb));
    initial begin
      int lat;
      logic [3:0] tr [16];
      logic [3:0] e;
      xs.req_valid = 1'b0;
      xs.req_a = 4'h1;
      xs.req_b = 4'h1;
      xs.req_op = 4'h1;
      xs.req_sel = 2'd3;
      xs.req_clr = 1'b0;
      xs.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 xrst = 1'b1;
      @(posedge clk);
      #1 xs.req_valid = 1'b1;
      @(posedge clk);
      #1 xs.req_valid = 1'b0;
      lat = 0;
      while (!xs.rsp_valid && lat < 16) begin
        tr[lat] = xi;
        lat++;
        @(posedge clk);
        #1;
      end
      chk($sformatf("lat_t%0d", T), 32'(lat), 32'(6 + T));
      for (int c = 0; c < 6 + T; c++) begin
        e = (c < 3) ? 4'(c + 1) : (c == 3) ? 4'h7 : (c < 4 + T) ? 4'h0 : (c == 4 + T) ? 4'h8 : 4'h9;
        chk($sformatf("trace_t%0d_%0d", T, c), 32'(tr[c]), 32'(e));
      end
      chk($sformatf("res_t%0d", T), 32'(xs.rsp_res), 32'h6);
      chk($sformatf("flags_t%0d", T), 32'(xs.rsp_flags), 32'h9);
      fin = 1'b1;
    end
  end

  initial begin
    logic [3:0] etr [7];
    logic [3:0] eb [3];
    int c;
    logic saw;
    etr = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h0, 4'h8, 4'h9};
    eb = '{4'h3, 4'h5, 4'h2};
    sq.req_valid = 1'b0;
    sq.req_a = 4'h0;
    sq.req_b = 4'h0;
    sq.req_op = 4'h0;
    sq.req_sel = 2'd0;
    sq.req_clr = 1'b0;
    sq.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(sq.req_ready), 0);
    chk("rst_instr", 32'(instr), 0);
    chk("rst_valid", 32'(sq.rsp_valid), 0);
    grst = 1'b1;
    chk("ready_pre_edge", 32'(sq.req_ready), 0);
    step;
    chk("ready_post_rst", 32'(sq.req_ready), 1);
    res_v = 4'h8;
    flg_v = 4'b0010;
    // abort mid-LDB with an asynchronous reset
    issue(4'h3, 4'h5, 4'h2, 2'd1, 1'b0);
    step;
    chk("ldb_instr", 32'(instr), 32'(I_RS2));
    #2 grst = 1'b0;
    #1;
    chk("abort_instr", 32'(instr), 0);
    chk("abort_oe", 32'(dut.oe), 0);
    chk("abort_valid", 32'(sq.rsp_valid), 0);
    chk("abort_state", 32'(dut.state), 32'(IDLE));
    chk("abort_ready", 32'(sq.req_ready), 0);
    @(posedge clk);
    #1 grst = 1'b1;
    step;
    chk("ready_after_abort", 32'(sq.req_ready), 1);
    issue(4'h3, 4'h5, 4'h2, 2'd1, 1'b0);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("trace%0d", k), 32'(instr), 32'(etr[k]));
      if (k < 3) chk($sformatf("bus_ld%0d", k), 32'(bus), 32'(eb[k]));
      else chk($sformatf("oe_off%0d", k), 32'(dut.oe), 0);
      chk("valid_early", 32'(sq.rsp_valid), 0);
      chk("ready_busy", 32'(sq.req_ready), 0);
      step;
    end
    chk("basic_valid", 32'(sq.rsp_valid), 1);
    chk("basic_res", 32'(sq.rsp_res), 32'h8);
    chk("basic_flags", 32'(sq.rsp_flags), 32'h2);
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(sq.rsp_valid), 1);
      chk("bp_res", 32'(sq.rsp_res), 32'h8);
      chk("bp_flags", 32'(sq.rsp_flags), 32'h2);
      chk("bp_ready", 32'(sq.req_ready), 0);
      chk("bp_instr", 32'(instr), 0);
      sq.req_valid = (k == 2);
      sq.req_clr = (k == 2);
      step;
    end
    sq.req_valid = 1'b0;
    sq.req_clr = 1'b0;
    chk("bp_pulse_ignored", 32'(instr), 0);
    sq.rsp_ready = 1'b1;
    step;
    chk("bp_release_valid", 32'(sq.rsp_valid), 0);
    chk("bp_release_ready", 32'(sq.req_ready), 1);
    sq.rsp_ready = 1'b0;
    issue(4'h0, 4'h0, 4'h0, 2'd0, 1'b1);
    chk("clr_instr", 32'(instr), 32'hF);
    chk("clr_ready", 32'(sq.req_ready), 0);
    step;
    chk("clr_done_instr", 32'(instr), 0);
    chk("clr_done_ready", 32'(sq.req_ready), 1);
    chk("clr_no_rsp", 32'(sq.rsp_valid), 0);
    step;
    chk("clr_no_rsp2", 32'(sq.rsp_valid), 0);
    sq.rsp_ready = 1'b1;
    res_v = 4'hA;
    flg_v = 4'h5;
    issue(4'h7, 4'h1, 4'h3, 2'd2, 1'b0);
    sq.req_a = 4'h2;
    sq.req_b = 4'h2;
    sq.req_op = 4'h0;
    sq.req_sel = 2'd0;
    sq.req_valid = 1'b1;
    c = 0;
    saw = 1'b0;
    while (!sq.rsp_valid && c < 20) begin
      saw |= (instr == 4'h6);
      step;
      c++;
    end
    chk("b2b_lat1", 32'(c), 7);
    chk("b2b_exe_sel2", 32'(saw), 1);
    chk("b2b_res1", 32'(sq.rsp_res), 32'hA);
    chk("b2b_flags1", 32'(sq.rsp_flags), 32'h5);
    res_v = 4'h4;
    flg_v = 4'h0;
    step;
    chk("b2b_idle_ready", 32'(sq.req_ready), 1);
    chk("b2b_idle_valid", 32'(sq.rsp_valid), 0);
    step;
    chk("b2b_accept", 32'(instr), 32'(I_RS1));
    chk("b2b_bus_a", 32'(bus), 32'h2);
    sq.req_valid = 1'b0;
    c = 0;
    while (!sq.rsp_valid && c < 20) begin
      step;
      c++;
    end
    chk("b2b_lat2", 32'(c), 7);
    chk("b2b_res2", 32'(sq.rsp_res), 32'h4);
    chk("b2b_flags2", 32'(sq.rsp_flags), 32'h0);
    c = 0;
    while (!(ext[0].fin && ext[1].fin) && c < 200) begin
      step;
      c++;
    end
    chk("ext_done", 32'({ext[1].fin, ext[0].fin}), 32'h3);
    chk("contention", 32'(overlap), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
